// File: rtl/ctrl_pipe_pkg.sv
// Shared encodings for the control pipe: opcode/function codes and FSM states.
package ctrl_pipe_pkg;

  localparam logic [1:0] kRTYPE = 2'b00;
  localparam logic [1:0] kGROP  = 2'b01;
  localparam logic [1:0] kEQ    = 2'b10;
  localparam logic [1:0] kFIG   = 2'b11;

  // Flush counter width; covers FLUSH_CYC up to 15.
  localparam int unsigned FcW = 4;

  typedef enum logic [1:0] {
    StRun,
    StBrWait,
    StFlush
  } state_e;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Fetch/decode/branch handshake bundle between the instruction source and ctrl_pipe.
interface ctrl_pipe_if #(
  parameter int unsigned IW = 9,
  parameter int unsigned CW = 8
);

  logic [IW-1:0] Instruction;
  logic          InstValid;
  logic          InstReady;
  logic          FlagValid;
  logic          FlagEq;
  logic          DecValid;
  logic [1:0]    Op;
  logic [1:0]    Func;
  logic          BranchEn;
  logic          GenRegEn;
  logic          BranchTaken;
  logic          Flush;
  logic [CW-1:0] TakenCount;

  modport master (
    output Instruction, InstValid, FlagValid, FlagEq,
    input  InstReady, DecValid, Op, Func, BranchEn, GenRegEn, BranchTaken, Flush, TakenCount
  );

  modport slave (
    input  Instruction, InstValid, FlagValid, FlagEq,
    output InstReady, DecValid, Op, Func, BranchEn, GenRegEn, BranchTaken, Flush, TakenCount
  );

endinterface

// File: rtl/ctrl_dec.sv
// Combinational instruction field decode: opcode, function, branch and register-target enables.
module ctrl_dec
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned IW = 9
) (
  input  logic [IW-1:0] instr_i,
  output logic [1:0]    op_o,
  output logic [1:0]    func_o,
  output logic          branch_en_o,
  output logic          gen_reg_en_o
);

  // Top bit and the low operand bits carry nothing the controller needs.
  logic unused_bits;
  assign unused_bits = ^{instr_i[IW-1], instr_i[IW-6:0]};

  assign op_o         = instr_i[IW-2:IW-3];
  assign func_o       = instr_i[IW-4:IW-5];
  assign branch_en_o  = (op_o == kRTYPE) && (func_o == kEQ);
  assign gen_reg_en_o = !((op_o == kGROP) && (func_o != kFIG));

endmodule

// File: rtl/ctrl_pipe.sv
// Instruction decode register stage with branch-resolve / flush FSM and taken-branch counter.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned IW        = 9,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CW        = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  ctrl_pipe_if.slave  bus
);

  state_e         state_q, state_d;
  logic [FcW-1:0] fcnt_q, fcnt_d;
  logic [CW-1:0]  tcnt_q, tcnt_d;
  logic           taken_d, flush_d, accept;

  logic [1:0] dec_op, dec_func;
  logic       dec_br, dec_gre;

  logic       dec_valid_q, br_q, gre_q, taken_q, flush_q;
  logic [1:0] op_q, func_q;

  ctrl_dec #(
    .IW(IW)
  ) u_dec (
    .instr_i      (bus.Instruction),
    .op_o         (dec_op),
    .func_o       (dec_func),
    .branch_en_o  (dec_br),
    .gen_reg_en_o (dec_gre)
  );

  assign bus.InstReady = (state_q == StRun);
  assign accept        = bus.InstValid && bus.InstReady;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    tcnt_d  = tcnt_q;
    taken_d = 1'b0;
    unique case (state_q)
      StRun: begin
        if (accept && dec_br) state_d = StBrWait;
      end
      StBrWait: begin
        if (bus.FlagValid) begin
          if (bus.FlagEq) begin
            state_d = StFlush;
            taken_d = 1'b1;
            fcnt_d  = FcW'(FLUSH_CYC);
            if (tcnt_q != '1) tcnt_d = tcnt_q + 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StFlush: begin
        fcnt_d = fcnt_q - 1'b1;
        if (fcnt_q == FcW'(1)) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // Flush output tracks the registered FLUSH state exactly.
  assign flush_d = (state_d == StFlush);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StRun;
      fcnt_q      <= '0;
      tcnt_q      <= '0;
      taken_q     <= 1'b0;
      flush_q     <= 1'b0;
      dec_valid_q <= 1'b0;
      op_q        <= 2'b00;
      func_q      <= 2'b00;
      br_q        <= 1'b0;
      gre_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      tcnt_q      <= tcnt_d;
      taken_q     <= taken_d;
      flush_q     <= flush_d;
      dec_valid_q <= accept;
      if (accept) begin
        op_q   <= dec_op;
        func_q <= dec_func;
        br_q   <= dec_br;
        gre_q  <= dec_gre;
      end
    end
  end

  assign bus.DecValid    = dec_valid_q;
  assign bus.Op          = op_q;
  assign bus.Func        = func_q;
  assign bus.BranchEn    = br_q;
  assign bus.GenRegEn    = gre_q;
  assign bus.BranchTaken = taken_q;
  assign bus.Flush       = flush_q;
  assign bus.TakenCount  = tcnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: decode vector table with scoreboard plus branch/flush sequences.
module tb_ctrl_pipe;
  import ctrl_pipe_pkg::*;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // dut_a: defaults; dut_b: wide instruction and narrow counter.
  ctrl_pipe_if #(.IW(9),  .CW(8)) ba ();
  ctrl_pipe_if #(.IW(12), .CW(2)) bb ();

  ctrl_pipe #(.IW(9),  .FLUSH_CYC(2), .CW(8)) dut_a (.Clk(Clk), .Reset_n(Reset_n), .bus(ba.slave));
  ctrl_pipe #(.IW(12), .FLUSH_CYC(2), .CW(2)) dut_b (.Clk(Clk), .Reset_n(Reset_n), .bus(bb.slave));

  typedef struct {
    logic       top;
    logic [1:0] op;
    logic [1:0] func;
    logic       br;
    logic       gre;
  } vec_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [1:0]  func;
    logic        br;
    logic        gre;
    logic [31:0] cyc;
  } dec_t;

  vec_t vecs[4];
  vec_t vbr;
  dec_t qa[$];
  dec_t qb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_a(input vec_t v);
    dec_t e;
    ba.Instruction = {v.top, v.op, v.func, 4'($urandom_range(0, 15))};
    ba.InstValid   = 1'b1;
    chk("a_inst_ready", 32'(ba.InstReady), 32'd1);
    e.op = v.op; e.func = v.func; e.br = v.br; e.gre = v.gre; e.cyc = cyc + 1;
    qa.push_back(e);
    tick();
    ba.InstValid = 1'b0;
  endtask

  task automatic send_b(input vec_t v);
    dec_t e;
    bb.Instruction = {v.top, v.op, v.func, 7'($urandom_range(0, 127))};
    bb.InstValid   = 1'b1;
    chk("b_inst_ready", 32'(bb.InstReady), 32'd1);
    e.op = v.op; e.func = v.func; e.br = v.br; e.gre = v.gre; e.cyc = cyc + 1;
    qb.push_back(e);
    tick();
    bb.InstValid = 1'b0;
  endtask

  // Scoreboards: every DecValid pulse must match the oldest outstanding acceptance.
  always @(negedge Clk) begin
    dec_t e;
    if (ba.DecValid) begin
      if (qa.size() == 0) chk("a_unexpected_decvalid", 32'd1, 32'd0);
      else begin
        e = qa.pop_front();
        chk("a_op", 32'(ba.Op), 32'(e.op));
        chk("a_func", 32'(ba.Func), 32'(e.func));
        chk("a_branch_en", 32'(ba.BranchEn), 32'(e.br));
        chk("a_gen_reg_en", 32'(ba.GenRegEn), 32'(e.gre));
        chk("a_latency", 32'(cyc), e.cyc);
      end
    end
    if (bb.DecValid) begin
      if (qb.size() == 0) chk("b_unexpected_decvalid", 32'd1, 32'd0);
      else begin
        e = qb.pop_front();
        chk("b_op", 32'(bb.Op), 32'(e.op));
        chk("b_func", 32'(bb.Func), 32'(e.func));
        chk("b_branch_en", 32'(bb.BranchEn), 32'(e.br));
        chk("b_gen_reg_en", 32'(bb.GenRegEn), 32'(e.gre));
        chk("b_latency", 32'(cyc), e.cyc);
      end
    end
  end

  initial begin
    logic [1:0] cnt_exp[5];
    logic       taken_exp[3];
    logic       flush_exp[3];
    logic       ready_exp[3];

    vecs[0] = '{1'b1, kGROP,  kFIG, 1'b0, 1'b1};
    vecs[1] = '{1'b0, kGROP,  kEQ,  1'b0, 1'b0};
    vecs[2] = '{1'b1, kRTYPE, kFIG, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 2'b11,  kEQ,  1'b0, 1'b1};
    vbr     = '{1'b1, kRTYPE, kEQ,  1'b1, 1'b1};
    cnt_exp   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    taken_exp = '{1'b1, 1'b0, 1'b0};
    flush_exp = '{1'b1, 1'b1, 1'b0};
    ready_exp = '{1'b0, 1'b0, 1'b1};

    ba.Instruction = '0; ba.InstValid = 1'b0; ba.FlagValid = 1'b0; ba.FlagEq = 1'b0;
    bb.Instruction = '0; bb.InstValid = 1'b0; bb.FlagValid = 1'b0; bb.FlagEq = 1'b0;

    repeat (2) tick();
    chk("rst_inst_ready", 32'(ba.InstReady), 32'd1);
    chk("rst_dec_valid", 32'(ba.DecValid), 32'd0);
    chk("rst_op", 32'(ba.Op), 32'd0);
    chk("rst_func", 32'(ba.Func), 32'd0);
    chk("rst_branch_en", 32'(ba.BranchEn), 32'd0);
    chk("rst_gen_reg_en", 32'(ba.GenRegEn), 32'd1);
    chk("rst_branch_taken", 32'(ba.BranchTaken), 32'd0);
    chk("rst_flush", 32'(ba.Flush), 32'd0);
    chk("rst_taken_count", 32'(ba.TakenCount), 32'd0);
    chk("rst_b_gen_reg_en", 32'(bb.GenRegEn), 32'd1);

    // Back-to-back non-branch decode; the first is taken on the first edge after reset release.
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) send_a(vecs[i]);
    tick();
    chk("a_hold_op", 32'(ba.Op), 32'(vecs[3].op));

    // Not-taken branch: resolves after 3 idle cycles, stray instructions ignored meanwhile.
    send_a(vbr);
    ba.Instruction = {1'b0, kGROP, kEQ, 4'h5};
    ba.InstValid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("nt_wait_ready", 32'(ba.InstReady), 32'd0);
      chk("nt_wait_flush", 32'(ba.Flush), 32'd0);
      tick();
    end
    ba.InstValid = 1'b0;
    ba.FlagValid = 1'b1;
    ba.FlagEq    = 1'b0;
    chk("nt_flag_ready", 32'(ba.InstReady), 32'd0);
    tick();
    ba.FlagValid = 1'b0;
    chk("nt_ready_back", 32'(ba.InstReady), 32'd1);
    chk("nt_taken", 32'(ba.BranchTaken), 32'd0);
    chk("nt_flush", 32'(ba.Flush), 32'd0);
    chk("nt_count", 32'(ba.TakenCount), 32'd0);

    // Taken branch: one-cycle BranchTaken, two flush cycles, then ready again.
    send_a(vbr);
    ba.FlagValid = 1'b1;
    ba.FlagEq    = 1'b1;
    tick();
    ba.FlagValid = 1'b0;
    ba.FlagEq    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("tk_branch_taken", 32'(ba.BranchTaken), 32'(taken_exp[i]));
      chk("tk_flush", 32'(ba.Flush), 32'(flush_exp[i]));
      chk("tk_inst_ready", 32'(ba.InstReady), 32'(ready_exp[i]));
      chk("tk_count", 32'(ba.TakenCount), 32'd1);
      tick();
    end

    // A flag presented while running must not resolve anything.
    ba.FlagValid = 1'b1;
    ba.FlagEq    = 1'b1;
    tick();
    ba.FlagValid = 1'b0;
    ba.FlagEq    = 1'b0;
    chk("run_flag_taken", 32'(ba.BranchTaken), 32'd0);
    chk("run_flag_ready", 32'(ba.InstReady), 32'd1);
    chk("run_flag_count", 32'(ba.TakenCount), 32'd1);

    // Wide-instruction decode on dut_b, including the FIG / non-FIG pair.
    for (int i = 0; i < 4; i++) send_b(vecs[i]);
    tick();

    // Saturating counter with CW = 2.
    for (int i = 0; i < 5; i++) begin
      send_b(vbr);
      bb.FlagValid = 1'b1;
      bb.FlagEq    = 1'b1;
      tick();
      bb.FlagValid = 1'b0;
      bb.FlagEq    = 1'b0;
      chk("sat_taken", 32'(bb.BranchTaken), 32'd1);
      chk("sat_count", 32'(bb.TakenCount), 32'(cnt_exp[i]));
      tick();
      tick();
      chk("sat_ready", 32'(bb.InstReady), 32'd1);
    end

    // Reset asserted in the second flush cycle.
    send_a(vbr);
    ba.FlagValid = 1'b1;
    ba.FlagEq    = 1'b1;
    tick();
    ba.FlagValid = 1'b0;
    ba.FlagEq    = 1'b0;
    tick();
    chk("mid_flush_flush", 32'(ba.Flush), 32'd1);
    chk("mid_flush_count", 32'(ba.TakenCount), 32'd2);
    Reset_n = 1'b0;
    #1;
    chk("arst_flush", 32'(ba.Flush), 32'd0);
    chk("arst_inst_ready", 32'(ba.InstReady), 32'd1);
    chk("arst_count", 32'(ba.TakenCount), 32'd0);
    chk("arst_b_count", 32'(bb.TakenCount), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    send_a(vecs[1]);
    repeat (3) tick();

    chk("a_scoreboard_empty", 32'(qa.size()), 32'd0);
    chk("b_scoreboard_empty", 32'(qb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter IW, default 9, instruction width in bits; legal range 9 to 16.
REQ-002 SHALL have parameter FLUSH_CYC, default 2, flush length in cycles after a taken branch; legal range 1 to 15.
REQ-003 SHALL have parameter CW, default 8, width of the taken-branch counter.
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port Instruction, input, IW bits: machine code from instrROM.
REQ-007 SHALL have port InstValid, input, 1 bit: Instruction is valid this cycle.
REQ-008 SHALL have port InstReady, output, 1 bit: block accepts an instruction this cycle.
REQ-009 SHALL have port FlagValid, input, 1 bit: FlagEq is valid this cycle.
REQ-010 SHALL have port FlagEq, input, 1 bit: ALU equality flag.
REQ-011 SHALL have port DecValid, output, 1 bit: decoded outputs are valid this cycle.
REQ-012 SHALL have port Op, output, 2 bits: decoded opcode field.
REQ-013 SHALL have port Func, output, 2 bits: decoded function field.
REQ-014 SHALL have port BranchEn, output, 1 bit: the decoded instruction is a branch.
REQ-015 SHALL have port GenRegEn, output, 1 bit: 1 writes a general register; 0 writes the op register.
REQ-016 SHALL have port BranchTaken, output, 1 bit: one-cycle pulse when a branch resolves taken.
REQ-017 SHALL have port Flush, output, 1 bit: downstream fetch/decode contents must be discarded.
REQ-018 SHALL have port TakenCount, output, CW bits: saturating count of taken branches.

Function
REQ-019 SHALL decode fields as follows: Op = Instruction[IW-2:IW-3]; Func = Instruction[IW-4:IW-5]; bit IW-1 is ignored.
REQ-020 SHALL set BranchEn = 1 iff Op == kRTYPE and Func == kEQ.
REQ-021 SHALL set GenRegEn = 0 iff Op == kGROP and Func != kFIG; otherwise GenRegEn = 1.
REQ-022 SHALL accept an instruction only when InstValid and InstReady are both 1.
REQ-023 SHALL register an accepted instruction's decode with 1-cycle latency: DecValid, Op, Func, BranchEn and GenRegEn are valid in the following cycle.
REQ-024 SHALL pulse DecValid for exactly one cycle per accepted instruction.
REQ-025 SHALL hold Op, Func, BranchEn and GenRegEn at their last values while DecValid = 0.
REQ-026 SHALL implement an FSM with states RUN, BR_WAIT and FLUSH.
REQ-027 SHALL drive InstReady = 1 only in RUN.
REQ-028 In RUN, SHALL move to BR_WAIT on the edge that accepts a branch instruction, and remain in RUN otherwise.
REQ-029 In RUN, SHALL ignore FlagValid.
REQ-030 In BR_WAIT, SHALL wait with no timeout for FlagValid = 1.
REQ-031 In BR_WAIT with FlagValid = 1 and FlagEq = 0, SHALL return to RUN with no pulse.
REQ-032 In BR_WAIT with FlagValid = 1 and FlagEq = 1, SHALL pulse BranchTaken one cycle, increment TakenCount, load the flush counter with FLUSH_CYC, and enter FLUSH.
REQ-033 SHALL assert Flush in FLUSH, decrement the flush counter each cycle, and return to RUN after exactly FLUSH_CYC cycles.
REQ-034 SHALL saturate TakenCount at 2^CW-1 with no wrap.
REQ-035 SHALL ignore InstValid in BR_WAIT and FLUSH; no instruction is accepted there.
REQ-036 SHALL register BranchTaken and Flush outputs.

Reset
REQ-037 On Reset_n = 0, SHALL immediately enter RUN, including mid-BR_WAIT or mid-FLUSH, abandoning any pending branch.
REQ-038 SHALL reset to: InstReady = 1 (combinational from state), DecValid = 0, Op = 0, Func = 0, BranchEn = 0, GenRegEn = 1, BranchTaken = 0, Flush = 0, TakenCount = 0, flush counter = 0.
REQ-039 SHALL accept the first instruction on the first rising edge after Reset_n deasserts.

Structure
REQ-040 SHALL take kRTYPE, kEQ, kGROP and kFIG from package definitions, and add an FSM state enum (RUN, BR_WAIT, FLUSH) to that package.
REQ-041 SHALL place the field decode (REQ-019 to REQ-021) in one combinational sub-module, ctrl_dec, parametrised by IW; ctrl_pipe registers its outputs.

Verification
REQ-042 Bench SHALL reset, then present 3 non-branch instructions back-to-back -> 3 DecValid pulses, each 1 cycle after acceptance, with InstReady constant at 1.
REQ-043 Bench SHALL present a kRTYPE/kEQ instruction, then FlagValid = 1 with FlagEq = 0 after 3 cycles -> BranchEn = 1, InstReady = 0 for 4 cycles, no Flush, TakenCount = 0.
REQ-044 Bench SHALL present a branch, then FlagEq = 1 with FlagValid = 1, at FLUSH_CYC = 2 -> BranchTaken pulses 1 cycle, Flush high exactly 2 cycles, TakenCount = 1, then InstReady = 1.
REQ-045 Bench SHALL run with CW = 2 through 5 taken branches -> TakenCount sequence 1, 2, 3, 3, 3.
REQ-046 Bench SHALL drive Reset_n low during the second FLUSH cycle -> Flush = 0 and InstReady = 1 immediately, TakenCount = 0.
REQ-047 Bench SHALL present a kGROP instruction with Func = kFIG, then one with another Func -> GenRegEn = 1, then 0; at IW = 12, the fields are taken from bits [10:9] and [8:7].
